vc_stream_arb4: RTL and testbench

Four-input valid/ready stream arbiter with a registered output stage. It sits directly upstream of a 4:1 mux datapath. It picks one of four requesting input streams by round-robin, and its 2-bit grant drives the select of a W-bit 4:1 mux. It then registers the selected message, so downstream FFT stages see a single clean stream along with the source index.

---
 rtl/vc_stream_arb_pkg.sv | 12 +
 rtl/vc_mux4.sv | 24 ++
 rtl/vc_rr_arb4.sv | 39 +++
 rtl/vc_stream_arb4.sv | 120 ++++++++++++
 tb/tb_vc_stream_arb4.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/vc_stream_arb_pkg.sv
// Shared constants and lock-state encoding for the four-input stream arbiter.
package vc_stream_arb_pkg;

    localparam int GNT_W = 2;
    localparam int N_IN  = 4;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/vc_mux4.sv
// Parameterised W-bit 4:1 mux used on the arbiter's message datapath.
module vc_mux4 #(
    parameter int W = 32
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [1:0]   sel,
    output logic [W-1:0] out
);

    always_comb begin
        out = in0;
        case (sel)
            2'd0: out = in0;
            2'd1: out = in1;
            2'd2: out = in2;
            2'd3: out = in3;
            default: out = in0;
        endcase
    end

endmodule

// File: rtl/vc_rr_arb4.sv
// Four-way round-robin grant search; owns the priority pointer, which advances past upd_idx on en.
module vc_rr_arb4
    import vc_stream_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  req,
    input  logic             en,
    input  logic [GNT_W-1:0] upd_idx,
    output logic [GNT_W-1:0] gnt_idx,
    output logic             gnt_val
);

    logic [GNT_W-1:0] ptr;
    logic [GNT_W-1:0] idx;

    // Walk from the farthest offset down so the closest requester to ptr wins last.
    always_comb begin
        gnt_idx = '0;
        gnt_val = 1'b0;
        idx     = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            idx = ptr + GNT_W'(k);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_val = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= upd_idx + GNT_W'(1);
        end
    end

endmodule

// File: rtl/vc_stream_arb4.sv
// Round-robin 4:1 valid/ready stream arbiter with a registered output stage.
// Optional packet lock is built when VC_STREAM_ARB4_LOCK_EN is defined.
//
//   state    | meaning
//   UNLOCKED | arbitrate every beat round-robin
//   LOCKED   | grant pinned to lock_idx until its in_last beat transfers
module vc_stream_arb4
    import vc_stream_arb_pkg::*;
#(
    parameter int W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IN-1:0]   in_val,
    output logic [N_IN-1:0]   in_rdy,
    input  logic [N_IN*W-1:0] in_msg,
    input  logic [N_IN-1:0]   in_last,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [W-1:0]      out_msg,
    output logic [GNT_W-1:0]  out_sel
);

    logic             pipe_rdy;
    logic             xfer;
    logic [GNT_W-1:0] arb_idx;
    logic             arb_val;
    logic [GNT_W-1:0] gnt_idx;
    logic             gnt_val;
    logic [W-1:0]     sel_msg;

    assign pipe_rdy = !out_val || out_rdy;

    vc_rr_arb4 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (in_val),
        .en      (xfer),
        .upd_idx (gnt_idx),
        .gnt_idx (arb_idx),
        .gnt_val (arb_val)
    );

`ifdef VC_STREAM_ARB4_LOCK_EN
    lock_state_t      state_q, state_d;
    logic [GNT_W-1:0] lock_idx_q, lock_idx_d;

    assign gnt_idx = (state_q == LOCKED) ? lock_idx_q : arb_idx;
    assign gnt_val = (state_q == LOCKED) ? in_val[lock_idx_q] : arb_val;

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            UNLOCKED: begin
                if (xfer && !in_last[gnt_idx]) begin
                    state_d    = LOCKED;
                    lock_idx_d = gnt_idx;
                end
            end
            LOCKED: begin
                if (xfer && in_last[lock_idx_q]) begin
                    state_d = UNLOCKED;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= UNLOCKED;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    logic unused_last;

    assign unused_last = ^in_last;
    assign gnt_idx     = arb_idx;
    assign gnt_val     = arb_val;
`endif

    // Gated by reset so no source sees a handshake while state is being cleared.
    always_comb begin
        in_rdy = '0;
        if (!reset && pipe_rdy && gnt_val) begin
            in_rdy[gnt_idx] = 1'b1;
        end
    end

    assign xfer = |in_rdy;

    vc_mux4 #(.W(W)) u_mux (
        .in0 (in_msg[0*W +: W]),
        .in1 (in_msg[1*W +: W]),
        .in2 (in_msg[2*W +: W]),
        .in3 (in_msg[3*W +: W]),
        .sel (gnt_idx),
        .out (sel_msg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_val <= 1'b0;
            out_msg <= '0;
            out_sel <= '0;
        end else if (xfer) begin
            out_val <= 1'b1;
            out_msg <= sel_msg;
            out_sel <= gnt_idx;
        end else if (out_rdy) begin
            out_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vc_stream_arb4.sv
// Randomised and directed bench for vc_stream_arb4 against a behavioural round-robin model.
module tb_vc_stream_arb4;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    in_val;
    logic [3:0]    in_rdy;
    logic [4*W-1:0] in_msg;
    logic [3:0]    in_last;
    logic          out_val;
    logic          out_rdy;
    logic [W-1:0]  out_msg;
    logic [1:0]    out_sel;

    vc_stream_arb4 #(.W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .in_last (in_last),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg),
        .out_sel (out_sel)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] msgs [4];

    // reference model state
    int           m_ptr;
    bit           m_oval;
    logic [W-1:0] m_omsg;
    int           m_osel;
    bit           m_locked;
    int           m_lidx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_ptr    = 0;
        m_oval   = 0;
        m_omsg   = '0;
        m_osel   = 0;
        m_locked = 0;
        m_lidx   = 0;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic ordy);
        int         g;
        bit         gv;
        bit         pipe;
        logic [3:0] er;
        @(negedge clk);
        chk("out_val", {31'b0, out_val}, {31'b0, m_oval});
        chk("out_sel", {30'b0, out_sel}, m_osel);
        chk("out_msg", out_msg, m_omsg);
        in_val  = v;
        in_last = l;
        out_rdy = ordy;
        for (int i = 0; i < 4; i++) in_msg[i*W +: W] = msgs[i];
        #1;
        pipe = !m_oval || ordy;
        g    = 0;
        gv   = 0;
        if (m_locked) begin
            g  = m_lidx;
            gv = v[g];
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!gv && v[(m_ptr + k) % 4]) begin
                    g  = (m_ptr + k) % 4;
                    gv = 1;
                end
            end
        end
        er = (pipe && gv) ? 4'(1 << g) : 4'b0000;
        chk("in_rdy", {28'b0, in_rdy}, {28'b0, er});
        if (er != 4'b0000) begin
            m_oval = 1;
            m_omsg = msgs[g];
            m_osel = g;
            m_ptr  = (g + 1) % 4;
`ifdef VC_STREAM_ARB4_LOCK_EN
            if (!m_locked && !l[g]) begin
                m_locked = 1;
                m_lidx   = g;
            end else if (m_locked && l[g]) begin
                m_locked = 0;
            end
`endif
        end else if (ordy) begin
            m_oval = 0;
        end
    endtask

    task automatic post_sel(input string tag, input int exp_sel);
        @(posedge clk);
        #1;
        chk(tag, {30'b0, out_sel}, exp_sel);
        chk({tag, "_msg"}, out_msg, msgs[exp_sel]);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        in_val = 4'b0000;
        reset  = 1'b1;
        #1;
        chk("rst_out_val", {31'b0, out_val}, 32'd0);
        chk("rst_in_rdy", {28'b0, in_rdy}, 32'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        in_val  = 4'b1111;
        in_last = 4'b1111;
        out_rdy = 1'b1;
        in_msg  = '0;
        for (int i = 0; i < 4; i++) msgs[i] = '0;
        model_clear();
        @(negedge clk);
        chk("in_rdy_in_reset", {28'b0, in_rdy}, 32'd0);
        chk("out_val_in_reset", {31'b0, out_val}, 32'd0);
        in_val = 4'b0000;
        @(negedge clk);
        reset = 1'b0;

        // idle after reset
        for (int i = 0; i < 5; i++) drive(4'b0000, 4'b1111, 1'b1);

        // all valid: rotate 0,1,2,3,0
        msgs[0] = 32'h0a0a0a0a;
        msgs[1] = 32'hb0b0b0b0;
        msgs[2] = 32'h0c0c0c0c;
        msgs[3] = 32'hd0d0d0d0;
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b1111, 1'b1);
            post_sel("rr_sel", i % 4);
        end

        // asynchronous reset with a beat held
        pulse_reset();
        drive(4'b1111, 4'b1111, 1'b1);
        post_sel("post_rst_sel", 0);

        // sparse requests alternate 1,3 and wrap
        for (int i = 0; i < 5; i++) begin
            drive(4'b1010, 4'b1111, 1'b1);
            post_sel("alt_sel", (i % 2 == 0) ? 1 : 3);
        end

        // backpressure holds the beat, then the next grant follows
        drive(4'b1111, 4'b1111, 1'b1);
        post_sel("bp_first", 2);
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 4'b1111, 1'b0);
            post_sel("bp_hold", 2);
        end
        drive(4'b1111, 4'b1111, 1'b1);
        post_sel("bp_next", 3);

`ifdef VC_STREAM_ARB4_LOCK_EN
        drive(4'b0010, 4'b1111, 1'b1);
        post_sel("lock_pre", 1);
        drive(4'b1111, 4'b0000, 1'b1);
        post_sel("lock_b0", 2);
        drive(4'b1111, 4'b0000, 1'b1);
        post_sel("lock_b1", 2);
        drive(4'b1111, 4'b0100, 1'b1);
        post_sel("lock_b2", 2);
        drive(4'b1111, 4'b1111, 1'b1);
        post_sel("lock_after", 3);
`endif

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) msgs[i] = $urandom;
            if ($urandom_range(0, 59) == 0) pulse_reset();
            drive(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
        end
        drive(4'b0000, 4'b1111, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
